// File: rtl/riscv_dmem_responder.sv
// Data-memory responder for the RISC-V core load/store port: word RAM behind a
// small IDLE/WAIT/RESP sequencer with programmable wait states and range checking.
//
// state  | meaning
// S_IDLE | waiting for en; request latched on the accepting edge
// S_WAIT | counting down wait states, inputs ignored
// S_RESP | one-cycle ready pulse; write committed on the edge that ends it
module riscv_dmem_responder #(
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] ddatout,
    input  logic        rw,
    input  logic        en,
    output logic [31:0] ddatin,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int         DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam bit         NO_WAIT = (WAIT_STATES == 0);

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [DEPTH_LOG2-1:0] r_word;
    logic                  r_rw;
    logic [31:0]           r_wdata;
    logic                  r_in_range;
    logic [31:0]           r_ddatin;
    logic                  r_ready;
    logic                  r_err;
    logic                  r_busy;
    logic [31:0]           r_ram [0:DEPTH-1];

    logic [31:0]           w_off;
    logic [DEPTH_LOG2-1:0] w_word;
    logic                  w_in_range;
    logic                  w_unused_off;
    logic                  w_go_idle;
    logic                  w_go_wait;
    logic [DEPTH_LOG2-1:0] w_rd_word;
    logic                  w_rd_rw;
    logic                  w_rd_ok;

    assign w_off        = mem_addr - BASE_ADDR;
    assign w_word       = w_off[DEPTH_LOG2+1:2];
    assign w_in_range   = (mem_addr >= BASE_ADDR) && (w_off[31:DEPTH_LOG2+2] == '0);
    assign w_unused_off = ^w_off[1:0];

    // Entering RESP from IDLE (zero wait states) uses the live inputs, otherwise the latched copy.
    assign w_go_idle = NO_WAIT && (r_state == S_IDLE) && en;
    assign w_go_wait = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_rd_word = w_go_idle ? w_word : r_word;
    assign w_rd_rw   = w_go_idle ? rw : r_rw;
    assign w_rd_ok   = w_go_idle ? w_in_range : r_in_range;

    always_ff @(posedge clk) begin
        if (r_state == S_RESP && r_rw && r_in_range) begin
            r_ram[r_word] <= r_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_word     <= '0;
            r_rw       <= 1'b0;
            r_wdata    <= 32'd0;
            r_in_range <= 1'b0;
            r_ddatin   <= 32'd0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_word     <= w_word;
                        r_rw       <= rw;
                        r_wdata    <= ddatout;
                        r_in_range <= w_in_range;
                        r_busy     <= 1'b1;
                        if (NO_WAIT) begin
                            r_state <= S_RESP;
                        end else begin
                            r_cnt   <= WS_LOAD;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Read data is fetched on the edge into RESP; write responses leave ddatin alone.
            if (w_go_idle || w_go_wait) begin
                r_ready <= 1'b1;
                r_err   <= ~w_rd_ok;
                if (!w_rd_rw) begin
                    r_ddatin <= w_rd_ok ? r_ram[w_rd_word] : 32'd0;
                end
            end
        end
    end

    assign ddatin = r_ddatin;
    assign ready  = r_ready;
    assign err    = r_err;
    assign busy   = r_busy;

endmodule
